// File: rtl/hive_mem_dma_pkg.sv
// Shared types for the hive main-memory DMA: data width and memory control word.
package hive_mem_dma_pkg;

    localparam int unsigned ALU_W = 32;

    typedef struct packed {
        logic wr;
        logic lit;
        logic sgn;
        logic hlf;
        logic byt;
    } mem_ctl_t;

endpackage

// File: rtl/hive_mem_dma.sv
// Word DMA between the hive main-memory port and a valid/ready stream pair.
// Reads are credit-limited against a small return FIFO so the 4-cycle memory latency never overflows it.
module hive_mem_dma
    import hive_mem_dma_pkg::*;
#(
    parameter int unsigned MEM_ADDR_W = 13,
    parameter int unsigned LEN_W      = 12,
    parameter int unsigned FIFO_D     = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  dir_i,
    input  logic [MEM_ADDR_W-1:0] addr_i,
    input  logic [LEN_W-1:0]      len_i,
    output logic                  busy_o,
    output logic                  done_o,
    input  logic                  slot_i,
    output logic                  mem_sel_o,
    output mem_ctl_t              mem_ctl_o,
    output logic [MEM_ADDR_W-1:0] mem_b_o,
    output logic [ALU_W-1:0]      mem_a_o,
    input  logic [ALU_W-1:0]      mem_4_i,
    output logic [ALU_W-1:0]      rd_data_o,
    output logic                  rd_vld_o,
    input  logic                  rd_rdy_i,
    input  logic [ALU_W-1:0]      wr_data_i,
    input  logic                  wr_vld_i,
    output logic                  wr_rdy_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_D);
    localparam int unsigned CNT_W = PTR_W + 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_WR    = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]            state, state_nxt;
    logic [MEM_ADDR_W-1:0] addr;
    logic [LEN_W-1:0]      rem;
    logic [3:0]            vld_sr;
    logic [CNT_W-1:0]      fifo_cnt;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [ALU_W-1:0]      fifo_mem [FIFO_D];

    logic                  issue, issue_rd, push, pop;
    logic [CNT_W-1:0]      credit;

    // Returns land in cycle issue+4, i.e. when the tracking bit reaches the top.
    assign push     = vld_sr[3];
    assign rd_vld_o = (fifo_cnt != '0);
    assign rd_data_o = rd_vld_o ? fifo_mem[rd_ptr] : '0;
    assign pop      = rd_vld_o & rd_rdy_i;
    assign credit   = fifo_cnt + CNT_W'(vld_sr[0]) + CNT_W'(vld_sr[1])
                    + CNT_W'(vld_sr[2]) + CNT_W'(vld_sr[3]);
    assign busy_o   = (state == S_RD) || (state == S_WR) || (state == S_DRAIN);
    assign done_o   = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        issue_rd  = 1'b0;
        wr_rdy_o  = 1'b0;
        mem_ctl_o = '0;
        mem_a_o   = '0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    if (len_i == '0) state_nxt = S_DONE;
                    else             state_nxt = dir_i ? S_WR : S_RD;
                end
            end
            S_RD: begin
                if (slot_i && (rem != '0) && (credit < CNT_W'(FIFO_D))) begin
                    issue    = 1'b1;
                    issue_rd = 1'b1;
                    if (rem == LEN_W'(1)) state_nxt = S_DRAIN;
                end
            end
            S_WR: begin
                wr_rdy_o = slot_i && (rem != '0);
                if (wr_rdy_o && wr_vld_i) begin
                    issue        = 1'b1;
                    mem_ctl_o.wr = 1'b1;
                    mem_a_o      = wr_data_i;
                    if (rem == LEN_W'(1)) state_nxt = S_DONE;
                end
            end
            S_DRAIN: begin
                // Leave as the last word pops so done_o trails the final pop by one cycle.
                if ((vld_sr == '0) && ((fifo_cnt == '0) || ((fifo_cnt == CNT_W'(1)) && pop)))
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        mem_sel_o = issue;
        mem_b_o   = issue ? addr : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            addr     <= '0;
            rem      <= '0;
            vld_sr   <= '0;
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            state  <= state_nxt;
            vld_sr <= {vld_sr[2:0], issue_rd};
            if ((state == S_IDLE) && start_i) begin
                addr <= addr_i & ~MEM_ADDR_W'(3);
                rem  <= len_i;
            end else if (issue) begin
                addr <= addr + MEM_ADDR_W'(4);
                rem  <= rem - LEN_W'(1);
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload storage needs no reset; occupancy gates everything read from it.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= mem_4_i;
    end

endmodule

// File: tb/tb_hive_mem_dma.sv
// Directed bench for hive_mem_dma with a 4-cycle-latency memory model that returns
// 0xD000_0000 | address for reads and garbage in every other cycle.
module tb_hive_mem_dma;
    import hive_mem_dma_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, dir_i, slot_i, rd_rdy_i, wr_vld_i;
    logic [12:0] addr_i;
    logic [11:0] len_i;
    logic [31:0] wr_data_i, mem_4_i;
    logic        busy_o, done_o, mem_sel_o, rd_vld_o, wr_rdy_o;
    mem_ctl_t    mem_ctl_o;
    logic [12:0] mem_b_o;
    logic [31:0] mem_a_o, rd_data_o;

    int total = 0;
    int bad   = 0;

    hive_mem_dma dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .dir_i(dir_i),
        .addr_i(addr_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
        .slot_i(slot_i), .mem_sel_o(mem_sel_o), .mem_ctl_o(mem_ctl_o),
        .mem_b_o(mem_b_o), .mem_a_o(mem_a_o), .mem_4_i(mem_4_i),
        .rd_data_o(rd_data_o), .rd_vld_o(rd_vld_o), .rd_rdy_i(rd_rdy_i),
        .wr_data_i(wr_data_i), .wr_vld_i(wr_vld_i), .wr_rdy_o(wr_rdy_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory model: read data valid exactly in cycle issue+4.
    logic [13:0] p0 = '0, p1 = '0, p2 = '0, p3 = '0;
    always @(posedge clk_i) begin
        p0 <= {mem_sel_o & ~mem_ctl_o.wr, mem_b_o};
        p1 <= p0;
        p2 <= p1;
        p3 <= p2;
    end
    assign mem_4_i = p3[13] ? (32'hD000_0000 | 32'(p3[12:0])) : 32'hDEAD_BEEF;

    function automatic logic [31:0] mdat(input logic [12:0] a);
        return 32'hD000_0000 | 32'(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch a read and collect it; optionally toggle slot_i and stall the sink.
    task automatic run_read(input string tag, input logic [12:0] base, input int n,
                            input bit toggle, input int stall);
        int ni = 0;
        int np = 0;
        int last_pop = -10;
        bit fin = 1'b0;
        logic [12:0] a;
        @(negedge clk_i);
        start_i = 1'b1; dir_i = 1'b0; addr_i = base; len_i = 12'(n);
        slot_i = 1'b1; rd_rdy_i = 1'b0;
        #1 chk({tag, "_start_nosel"}, 32'(mem_sel_o), 32'd0);
        @(negedge clk_i);
        start_i = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            slot_i   = toggle ? ((c % 2) == 0) : 1'b1;
            rd_rdy_i = (c >= stall);
            #1;
            if (c == 0) chk({tag, "_wrrdy_low"}, 32'(wr_rdy_o), 32'd0);
            if (stall > 0 && c == stall) chk({tag, "_credit_stop"}, 32'(ni), 32'd8);
            if (mem_sel_o) begin
                a = (base & ~13'd3) + 13'(4 * ni);
                chk({tag, "_sel_slot"}, 32'(slot_i), 32'd1);
                chk({tag, "_rd_wr0"}, 32'(mem_ctl_o.wr), 32'd0);
                chk({tag, "_rd_addr"}, 32'(mem_b_o), 32'(a));
                ni++;
            end
            if (done_o) begin
                chk({tag, "_done_cnt"}, 32'(np), 32'(n));
                chk({tag, "_done_lat"}, 32'(last_pop), 32'(c - 1));
                chk({tag, "_done_busy"}, 32'(busy_o), 32'd0);
                fin = 1'b1;
            end
            if (rd_vld_o && rd_rdy_i) begin
                a = (base & ~13'd3) + 13'(4 * np);
                chk({tag, "_data"}, rd_data_o, mdat(a));
                np++;
                last_pop = c;
            end
            @(negedge clk_i);
        end
        chk({tag, "_finished"}, 32'(fin), 32'd1);
        chk({tag, "_issues"}, 32'(ni), 32'(n));
        slot_i = 1'b0; rd_rdy_i = 1'b0;
    endtask

    initial begin
        logic [31:0] wdat [3];
        wdat[0] = 32'hA; wdat[1] = 32'hB; wdat[2] = 32'hC;
        rst_i = 1'b1; start_i = 1'b0; dir_i = 1'b0; addr_i = '0; len_i = '0;
        slot_i = 1'b1; rd_rdy_i = 1'b1; wr_vld_i = 1'b1; wr_data_i = 32'h5555;

        // Reset: every output zero even with stimulus present.
        @(negedge clk_i); @(negedge clk_i);
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_outs", 32'({mem_sel_o, rd_vld_o, wr_rdy_o, mem_ctl_o}), 32'd0);
        chk("rst_b", 32'(mem_b_o), 32'd0);
        chk("rst_a", mem_a_o, 32'd0);
        chk("rst_rdata", rd_data_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0; wr_vld_i = 1'b0; rd_rdy_i = 1'b0;

        // Write of 3 words from an unaligned start address.
        @(negedge clk_i);
        start_i = 1'b1; dir_i = 1'b1; addr_i = 13'h103; len_i = 12'd3; slot_i = 1'b0;
        #1 chk("wr_idle_rdy", 32'(wr_rdy_o), 32'd0);
        @(negedge clk_i);
        start_i = 1'b0; wr_vld_i = 1'b1; wr_data_i = wdat[0];
        #1;
        chk("wr_busy", 32'(busy_o), 32'd1);
        chk("wr_noslot", 32'({wr_rdy_o, mem_sel_o}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            slot_i = 1'b1; wr_data_i = wdat[i];
            #1;
            chk("wr_rdy", 32'(wr_rdy_o), 32'd1);
            chk("wr_sel", 32'({mem_sel_o, mem_ctl_o.wr}), 32'd3);
            chk("wr_addr", 32'(mem_b_o), 32'h100 + 32'(4 * i));
            chk("wr_data", mem_a_o, wdat[i]);
        end
        @(negedge clk_i);
        wr_vld_i = 1'b0;
        #1;
        chk("wr_done", 32'(done_o), 32'd1);
        chk("wr_done_idle", 32'({busy_o, mem_sel_o, wr_rdy_o, mem_ctl_o.wr}), 32'd0);
        @(negedge clk_i);
        #1 chk("wr_done_pulse", 32'(done_o), 32'd0);

        // Zero-length transfer: straight to DONE without touching memory.
        @(negedge clk_i);
        start_i = 1'b1; dir_i = 1'b0; addr_i = 13'h20; len_i = 12'd0; slot_i = 1'b1;
        #1 chk("len0_nosel0", 32'(mem_sel_o), 32'd0);
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        chk("len0_done", 32'({done_o, busy_o, mem_sel_o}), 32'b100);
        @(negedge clk_i);
        #1 chk("len0_after", 32'({done_o, busy_o, mem_sel_o}), 32'd0);

        // Stalled sink: credit stops issue at 8, then all 20 words in order.
        run_read("stall", 13'h40, 20, 1'b0, 20);
        // Slot gaps: issues only in slot cycles, returns at issue+4.
        run_read("gap", 13'h10, 4, 1'b1, 0);
        // Top word wraps to address 0.
        run_read("wrap", 13'h1FFC, 2, 1'b0, 0);

        // Start while busy is ignored; reset with 3 reads in flight aborts.
        @(negedge clk_i);
        start_i = 1'b1; dir_i = 1'b0; addr_i = 13'h200; len_i = 12'd6; slot_i = 1'b1;
        rd_rdy_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        #1 chk("ab_first", 32'(mem_b_o), 32'h200);
        @(negedge clk_i);
        start_i = 1'b1; dir_i = 1'b1; addr_i = 13'h300; len_i = 12'd1;
        #1;
        chk("ab_ign_addr", 32'(mem_b_o), 32'h204);
        chk("ab_ign_wr", 32'({mem_ctl_o.wr, wr_rdy_o}), 32'd0);
        @(negedge clk_i);
        start_i = 1'b0;
        #1 chk("ab_third", 32'({busy_o, mem_sel_o, mem_b_o}), {16'd0, 1'b1, 1'b1, 13'h208});
        @(negedge clk_i);
        slot_i = 1'b0; rst_i = 1'b1;
        #1 chk("ab_rst", 32'({busy_o, mem_sel_o, rd_vld_o, done_o}), 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1 chk("ab_stale", 32'({rd_vld_o, done_o, busy_o}), 32'd0);
            @(negedge clk_i);
        end
        run_read("recover", 13'h80, 3, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
